// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - video sync/data delay line with frame-aligned delay switching and flush mask
module sync_delay_line #(
  parameter int DATA_W     = 24,
  parameter int MAX_DELAY  = 16,
  parameter int INIT_DELAY = 1,
  parameter int DLY_W      = $clog2(MAX_DELAY + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DLY_W-1:0]  delay_cfg,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [DATA_W-1:0] data_out,
  output logic [DLY_W-1:0]  active_delay,
  output logic              cfg_pending
);

  localparam int SW     = DATA_W + 3;
  localparam int INIT_C = (INIT_DELAY < 1) ? 1 :
                          (INIT_DELAY > MAX_DELAY) ? MAX_DELAY : INIT_DELAY;
  localparam logic [DLY_W-1:0] INIT_D = DLY_W'(INIT_C);

  function automatic logic [DLY_W-1:0] clamp_dly(input logic [DLY_W-1:0] v);
    if (v == '0)
      return DLY_W'(1);
    else if (v > DLY_W'(MAX_DELAY))
      return DLY_W'(MAX_DELAY);
    else
      return v;
  endfunction

  logic [SW-1:0]    stage_q [MAX_DELAY];
  logic [SW-1:0]    stage_d [MAX_DELAY];
  logic             vs_prev_q, vs_prev_d;
  logic [DLY_W-1:0] active_delay_q, active_delay_d;
  logic [DLY_W-1:0] mask_q, mask_d;
  logic [DLY_W-1:0] cfg_clamped;
  logic             vs_rise;
  logic [SW-1:0]    tap;

  always_comb begin
    stage_d[0] = {vs_in, hs_in, de_in, data_in};
    for (int k = 1; k < MAX_DELAY; k++)
      stage_d[k] = stage_q[k-1];
  end

  assign cfg_clamped = clamp_dly(delay_cfg);
  assign vs_rise     = vs_in & ~vs_prev_q;

  // Delay only changes on a frame edge; a real change opens a flush window
  // covering the cycles that would otherwise show stale or duplicated pixels.
  always_comb begin
    vs_prev_d      = vs_in;
    active_delay_d = active_delay_q;
    mask_d         = mask_q;
    if (mask_q != '0)
      mask_d = mask_q - DLY_W'(1);
    if (vs_rise) begin
      active_delay_d = cfg_clamped;
      if (cfg_clamped != active_delay_q)
        mask_d = cfg_clamped;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MAX_DELAY; k++)
        stage_q[k] <= '0;
      vs_prev_q      <= 1'b0;
      active_delay_q <= INIT_D;
      mask_q         <= '0;
    end else begin
      for (int k = 0; k < MAX_DELAY; k++)
        stage_q[k] <= stage_d[k];
      vs_prev_q      <= vs_prev_d;
      active_delay_q <= active_delay_d;
      mask_q         <= mask_d;
    end
  end

  always_comb begin
    tap = '0;
    for (int k = 0; k < MAX_DELAY; k++)
      if (active_delay_q == DLY_W'(k + 1))
        tap = stage_q[k];
  end

  assign vs_out       = tap[SW-1];
  assign hs_out       = tap[SW-2];
  assign de_out       = tap[SW-3] & (mask_q == '0);
  assign data_out     = de_out ? tap[DATA_W-1:0] : '0;
  assign active_delay = active_delay_q;
  assign cfg_pending  = (cfg_clamped != active_delay_q);

endmodule

// File: tb/tb_sync_delay_line.sv
// tb/tb_sync_delay_line.sv - self-checking bench for sync_delay_line
module tb_sync_delay_line;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] delay_cfg = 4'd3;
  logic       vs_out, hs_out, de_out, cfg_pending;
  logic [7:0] data_out;
  logic [3:0] active_delay;

  sync_delay_line #(
    .DATA_W(8), .MAX_DELAY(8), .INIT_DELAY(3), .DLY_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .data_in(data_in),
    .delay_cfg(delay_cfg),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .data_out(data_out),
    .active_delay(active_delay), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [10:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic       hs;
    logic       de;
    logic [7:0] data;
    logic       exp_hs;
    logic       exp_de;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic sb_push(input int dly, input logic [10:0] exp);
    sb_t s;
    s.due = cyc + dly;
    s.exp = exp;
    sbq.push_back(s);
  endtask

  // One cycle: drive inputs just after the edge, then compare whatever is due.
  task automatic step(input logic r, input logic v, input logic h, input logic e,
                      input logic [7:0] d, input logic [3:0] cfg);
    sb_t s;
    @(posedge clk);
    #1;
    cyc++;
    reset = r; vs_in = v; hs_in = h; de_in = e; data_in = d; delay_cfg = cfg;
    #1;
    while (sbq.size() > 0 && sbq[0].due == cyc) begin
      s = sbq.pop_front();
      check("sb_out", {vs_out, hs_out, de_out, data_out}, s.exp);
    end
  endtask

  initial begin
    logic [7:0] dv;
    logic [3:0] cv;
    int         guard;

    vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5};
    vecs[4] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[7] = '{1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 8'h81};
    vecs[8] = '{1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 8'h00};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};

    // Reset held two cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd3);
    check("rst_vs_out", vs_out, 1'b0);
    check("rst_hs_out", hs_out, 1'b0);
    check("rst_de_out", de_out, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_active_delay", active_delay, 4'd3);
    check("rst_cfg_pending", cfg_pending, 1'b0);

    // Fixed delay of 3 from the vector table
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, vecs[i].hs, vecs[i].de, vecs[i].data, 4'd3);
      sb_push(3, {1'b0, vecs[i].exp_hs, vecs[i].exp_de, vecs[i].exp_data});
    end

    // Mid-frame requests never take effect and never mask
    for (int i = 0; i < 100; i++) begin
      cv = 4'($urandom_range(4, 15));
      dv = 8'($urandom);
      step(1'b0, 1'b0, 1'b0, 1'b1, dv, cv);
      check("midframe_active", active_delay, 4'd3);
      check("midframe_pending", cfg_pending, 1'b1);
      sb_push(3, {1'b0, 1'b0, 1'b1, dv});
    end
    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd3);
      guard++;
    end
    check("sb_drained", sbq.size(), 0);
    sbq.delete();

    // Clamp: 0 -> 1, 12 -> 8
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    check("clamp0_pending", cfg_pending, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    check("clamp0_active", active_delay, 4'd1);
    check("clamp0_pending_clr", cfg_pending, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd12);
    check("clamp12_pending", cfg_pending, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd12);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd12);
    check("clamp12_active", active_delay, 4'd8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd3);
    check("back_to_3", active_delay, 4'd3);
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd3);

    // Frame switch 3 -> 5 with de_in held high
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 4'd5);
      check("switch_pending", cfg_pending, 1'b1);
      check("switch_hold3", active_delay, 4'd3);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 4'd5);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 4'd5);
      check("switch_active5", active_delay, 4'd5);
      check("switch_pending_clr", cfg_pending, 1'b0);
      check("switch_mask_de", de_out, 1'b0);
      check("switch_mask_data", data_out, 8'h00);
      check("switch_vs_out", vs_out, (k == 5) ? 1'b1 : 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 4'd5);
    check("switch_unmask_de", de_out, 1'b1);
    check("switch_unmask_data", data_out, 8'h5A);

    // Reset in the middle of a long flush clears it
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd8);
    check("flush_active8", active_delay, 4'd8);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 4'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 4'd8);
    check("rstflush_out", {vs_out, hs_out, de_out, data_out}, 11'h000);
    check("rstflush_active", active_delay, 4'd3);
    check("rstflush_pending", cfg_pending, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 4'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 4'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 4'd8);
    check("rstflush_de", de_out, 1'b1);
    check("rstflush_data", data_out, 8'h77);

    // vs_in already high right after reset still counts as an edge
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd5);
    check("postrst_init", active_delay, 4'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd5);
    check("postrst_rise", active_delay, 4'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_delay_line.md
SYNC_DELAY_LINE -- requirements
Module: sync_delay_line

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 24, pixel data width carried alongside sync.
- MAX_DELAY, 16, deepest selectable delay in cycles, >=2.
- INIT_DELAY, 1, active delay after reset, clamped per REQ-008.
- DLY_W, clog2(MAX_DELAY+1), width of delay fields.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, synchronous active-high reset.
- vs_in, in, 1, vertical sync.
- hs_in, in, 1, horizontal sync.
- de_in, in, 1, data enable.
- data_in, in, DATA_W, pixel data.
- delay_cfg, in, DLY_W, requested delay.
- vs_out, out, 1, delayed vs_in.
- hs_out, out, 1, delayed hs_in.
- de_out, out, 1, delayed and masked de_in.
- data_out, out, DATA_W, delayed and masked data_in.
- active_delay, out, DLY_W, delay currently applied.
- cfg_pending, out, 1, high when clamp(delay_cfg) != active_delay.

REQ-003 The block SHALL use one clock and a synchronous, active-high reset.

Function
REQ-004 Pipeline: MAX_DELAY registered stages, each holding {vs, hs, de, data}; stage 0 loads inputs every cycle, stage k loads stage k-1.
REQ-005 Output tap: outputs SHALL come from stage active_delay-1, so input sampled in cycle n appears in cycle n+active_delay; no combinational input-to-output path.
REQ-006 Frame edge: vs_rise = vs_in & ~vs_prev; vs_prev is a register of vs_in and resets to 0.
REQ-007 Delay update: in a cycle with vs_rise, active_delay SHALL load clamp(delay_cfg) at that cycle's end; delay_cfg is ignored in all other cycles (no mid-frame change).
REQ-008 Clamp: 0 -> 1; values >MAX_DELAY -> MAX_DELAY; otherwise unchanged.
REQ-009 Alignment: a vs_rise in cycle t SHALL appear on vs_out in cycle t+d_new, where d_new is the delay loaded at t.
REQ-010 Flush mask: if the loaded value differs from the previous active_delay, de_out and data_out SHALL be forced to 0 in cycles t+1 through t+d_new inclusive; no mask if the value is unchanged.
REQ-011 A vs_rise during an active mask SHALL restart the mask from the new edge using the newly loaded delay, if the value changes again.
REQ-012 vs_out and hs_out SHALL never be masked.
REQ-013 data_out SHALL be 0 whenever de_out is 0; otherwise it equals the tapped data.
REQ-014 cfg_pending SHALL be combinational from delay_cfg and active_delay.

Reset
REQ-015 After a clock edge with reset=1:
- all stages = 0;
- vs_prev = 0;
- mask counter = 0;
- active_delay = clamp(INIT_DELAY);
- vs_out, hs_out, de_out and data_out = 0 from the next cycle.
REQ-016 Reset SHALL override any in-progress flush or pending update.
REQ-017 If vs_in=1 in the first cycle after reset, that cycle SHALL count as vs_rise.

Verification
Configuration for all scenarios: DATA_W=8, MAX_DELAY=8, INIT_DELAY=3.
REQ-018 Reset: reset held 2 cycles with delay_cfg=3 -> all outputs 0, active_delay=3, cfg_pending=0.
REQ-019 Fixed delay: de_in=1 and data_in=0xA5 in cycle 10 only -> de_out=1 and data_out=0xA5 in cycle 13 only; hs pulse is likewise delayed by 3 cycles.
REQ-020 Clamp:
- delay_cfg=0 plus a vs_rise -> active_delay=1.
- delay_cfg=12 plus a vs_rise -> active_delay=8.
REQ-021 Frame switch:
- delay_cfg=5 from cycle 20 -> cfg_pending=1 and active_delay stays 3.
- vs_in rises in cycle 30 -> active_delay=5 from cycle 31 and cfg_pending=0.
- de_out=0 in cycles 31-35 even with de_in=1 throughout.
- vs_out rises in cycle 35.
REQ-022 Mid-frame request: delay_cfg changed with no vs_rise for 100 cycles -> active_delay unchanged, no masking, and cfg_pending stays 1.
REQ-023 Reset mid-flush: reset=1 in cycle 33 during the REQ-021 mask -> all outputs 0 from cycle 34, active_delay=3, and the mask is cleared.
